// File: rtl/mac_if_pkg.sv
// Shared types for the RX store-and-forward path: commit controller states,
// the frame descriptor record and a saturating-increment helper.
package mac_if_pkg;

  localparam int DESC_FIELD_W = 16;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_VERDICT,
    ST_DROP
  } rx_commit_state_t;

  // Fields are sized for the widest supported buffer; the top slices them down.
  typedef struct packed {
    logic [DESC_FIELD_W-1:0] start;
    logic [DESC_FIELD_W-1:0] len;
  } rx_desc_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import mac_if_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= sat_inc(count_reg);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/rx_frame_commit_ctrl.sv
// Writes received frames into the RX byte ring speculatively and only exposes
// them to the consumer (pointer + descriptor) once the CRC verdict window closes clean.
module rx_frame_commit_ctrl
  import mac_if_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int LEN_W        = 11,
  parameter int MAX_LEN      = 1518,
  parameter int VERDICT_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_sof_i,
  input  logic              rx_eof_i,
  input  logic              invalid_frame_i,
  input  logic [ADDR_W:0]   rd_ptr_i,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_waddr_o,
  output logic [7:0]        buf_wdata_o,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_start_o,
  output logic [LEN_W-1:0]  desc_len_o,
  output logic [15:0]       drop_crc_cnt_o,
  output logic [15:0]       drop_ovf_cnt_o
);

  localparam int PTR_W   = ADDR_W + 1;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int TIMER_W = $clog2(VERDICT_WAIT + 1);

  rx_commit_state_t state_reg, state_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   commit_ptr_reg, commit_ptr_next;
  logic [ADDR_W-1:0]  start_reg, start_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               buf_we_reg, buf_we_next;
  logic [ADDR_W-1:0]  buf_waddr_reg, buf_waddr_next;
  logic [7:0]         buf_wdata_reg, buf_wdata_next;
  rx_desc_t           desc_reg;
  logic               desc_valid_reg;

  logic               commit;
  logic               crc_inc;
  logic               ovf_inc;
  logic               start_frame;
  logic               slot_busy;
  logic [PTR_W-1:0]   base_ptr;
  logic               unused_desc;

  // Free bytes as seen from a write pointer; 0 means the ring is full.
  function automatic logic [PTR_W-1:0] free_of(input logic [PTR_W-1:0] ptr,
                                               input logic [PTR_W-1:0] rd);
    logic [PTR_W-1:0] used;
    used = ptr - rd;
    return PTR_W'(DEPTH) - used;
  endfunction

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    start_next      = start_reg;
    len_next        = len_reg;
    timer_next      = timer_reg;
    buf_we_next     = 1'b0;
    buf_waddr_next  = buf_waddr_reg;
    buf_wdata_next  = buf_wdata_reg;
    commit          = 1'b0;
    crc_inc         = 1'b0;
    ovf_inc         = 1'b0;
    start_frame     = 1'b0;
    base_ptr        = commit_ptr_reg;
    slot_busy       = desc_valid_reg & ~desc_ready_i;

    case (state_reg)
      ST_IDLE: begin
        start_frame = rx_valid_i & rx_sof_i;
      end

      ST_RECV: begin
        if (rx_valid_i && rx_sof_i) begin
          // A second SOF aborts the frame in flight; the new frame restarts below.
          ovf_inc     = 1'b1;
          start_frame = 1'b1;
        end else if (rx_valid_i) begin
          if (free_of(wr_ptr_reg, rd_ptr_i) == '0 || len_reg == LEN_W'(MAX_LEN)) begin
            wr_ptr_next = commit_ptr_reg;
            ovf_inc     = 1'b1;
            state_next  = rx_eof_i ? ST_IDLE : ST_DROP;
          end else begin
            buf_we_next    = 1'b1;
            buf_waddr_next = wr_ptr_reg[ADDR_W-1:0];
            buf_wdata_next = rx_data_i;
            wr_ptr_next    = wr_ptr_reg + 1'b1;
            len_next       = len_reg + 1'b1;
            if (rx_eof_i) begin
              if (invalid_frame_i) begin
                wr_ptr_next = commit_ptr_reg;
                crc_inc     = 1'b1;
                state_next  = ST_IDLE;
              end else begin
                timer_next = '0;
                state_next = ST_VERDICT;
              end
            end
          end
        end
      end

      ST_VERDICT: begin
        if (timer_reg == TIMER_W'(VERDICT_WAIT) ||
            (rx_valid_i && rx_sof_i && !invalid_frame_i)) begin
          commit          = 1'b1;
          commit_ptr_next = wr_ptr_reg;
          base_ptr        = wr_ptr_reg;
          slot_busy       = 1'b1;
          state_next      = ST_IDLE;
        end else if (invalid_frame_i) begin
          wr_ptr_next = commit_ptr_reg;
          crc_inc     = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
        start_frame = rx_valid_i & rx_sof_i;
      end

      ST_DROP: begin
        if (rx_valid_i && rx_eof_i) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // First byte of a frame, built on whatever pointer the current cycle resolved to.
    if (start_frame) begin
      if (!slot_busy && free_of(base_ptr, rd_ptr_i) != '0) begin
        buf_we_next    = 1'b1;
        buf_waddr_next = base_ptr[ADDR_W-1:0];
        buf_wdata_next = rx_data_i;
        wr_ptr_next    = base_ptr + 1'b1;
        start_next     = base_ptr[ADDR_W-1:0];
        len_next       = LEN_W'(1);
        timer_next     = '0;
        state_next     = rx_eof_i ? ST_VERDICT : ST_RECV;
      end else begin
        ovf_inc     = 1'b1;
        wr_ptr_next = base_ptr;
        state_next  = rx_eof_i ? ST_IDLE : ST_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      start_reg      <= '0;
      len_reg        <= '0;
      timer_reg      <= '0;
      buf_we_reg     <= 1'b0;
      buf_waddr_reg  <= '0;
      buf_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      start_reg      <= start_next;
      len_reg        <= len_next;
      timer_reg      <= timer_next;
      buf_we_reg     <= buf_we_next;
      buf_waddr_reg  <= buf_waddr_next;
      buf_wdata_reg  <= buf_wdata_next;
    end
  end

  // One-entry descriptor slot; a load only happens when the slot is known empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      desc_reg       <= '0;
      desc_valid_reg <= 1'b0;
    end else if (commit) begin
      desc_reg.start <= DESC_FIELD_W'(start_reg);
      desc_reg.len   <= DESC_FIELD_W'(len_reg);
      desc_valid_reg <= 1'b1;
    end else if (desc_valid_reg && desc_ready_i) begin
      desc_valid_reg <= 1'b0;
    end
  end

  sat_counter u_crc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (crc_inc),
    .count (drop_crc_cnt_o)
  );

  sat_counter u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ovf_inc),
    .count (drop_ovf_cnt_o)
  );

  assign unused_desc  = ^desc_reg;
  assign buf_we_o     = buf_we_reg;
  assign buf_waddr_o  = buf_waddr_reg;
  assign buf_wdata_o  = buf_wdata_reg;
  assign desc_valid_o = desc_valid_reg;
  assign desc_start_o = desc_reg.start[ADDR_W-1:0];
  assign desc_len_o   = desc_reg.len[LEN_W-1:0];

endmodule

// File: doc/rx_frame_commit_ctrl.md
# rx_frame_commit_ctrl

Store-and-forward write controller downstream of the RX MAC. Writes each received frame byte-by-byte into a byte ring buffer, waits for the MAC's CRC verdict, then commits the frame and publishes a descriptor, or rolls the write pointer back and drops the frame. It sequences the shared RX buffer so that only complete, CRC-clean frames are ever visible to the consumer.

## Interface
- ADDR_W, 11: ring buffer address width; depth = 2^ADDR_W bytes.
- LEN_W, 11: descriptor length width.
- MAX_LEN, 1518: longest accepted frame in bytes; longer frames are dropped.
- VERDICT_WAIT, 4: cycles after EOF during which invalid_frame_i is honoured.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- rx_valid_i  in  1  rx_data_i carries a frame byte this cycle.
- rx_data_i  in  8  frame byte, destination MAC first, FCS included.
- rx_sof_i  in  1  qualifies with rx_valid_i; first byte of the frame.
- rx_eof_i  in  1  qualifies with rx_valid_i; last byte of the frame.
- invalid_frame_i  in  1  single-cycle CRC-error pulse from the MAC.
- rd_ptr_i  in  ADDR_W+1  consumer's free pointer (wrap bit included).
- buf_we_o  out  1  buffer write enable.
- buf_waddr_o  out  ADDR_W  buffer write address.
- buf_wdata_o  out  8  buffer write data.
- desc_valid_o  out  1  descriptor available.
- desc_ready_i  in  1  consumer accepts the descriptor.
- desc_start_o  out  ADDR_W  buffer address of the frame's first byte.
- desc_len_o  out  LEN_W  frame length in bytes.
- drop_crc_cnt_o  out  16  saturating count of CRC drops.
- drop_ovf_cnt_o  out  16  saturating count of space, descriptor, oversize or protocol drops.

## Operation
- Pointers: wr_ptr is speculative and commit_ptr is committed. Both are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- free = 2^ADDR_W − (wr_ptr − rd_ptr_i), computed modulo 2^(ADDR_W+1).
- IDLE:
  - rx_valid_i & rx_sof_i with the descriptor slot empty (or emptying this cycle) and free > 0: write the byte, latch start = commit_ptr, set len = 1, go to RECV.
  - If the slot stays full or free == 0: increment drop_ovf_cnt_o, go to DROP.
  - A byte with rx_valid_i but no rx_sof_i is ignored.
- RECV: each valid byte is written and increments wr_ptr and len.
  - free == 0 or len == MAX_LEN on a new byte: the byte is not written, wr_ptr ← commit_ptr, increment drop_ovf_cnt_o, go to DROP (or IDLE if that byte is EOF).
  - EOF byte written: go to VERDICT with timer = 0.
  - rx_sof_i in RECV: treat as a protocol error. Roll back, count as ovf, restart the frame from this byte as in IDLE.
- VERDICT:
  - invalid_frame_i seen on the EOF cycle or during the timer: wr_ptr ← commit_ptr, increment drop_crc_cnt_o, go to IDLE.
  - Timer reaches VERDICT_WAIT with no error: commit_ptr ← wr_ptr, load the descriptor (start, len), go to IDLE.
  - rx_sof_i in VERDICT: resolve immediately using invalid_frame_i of that cycle, then handle the byte as in IDLE.
- DROP: discard bytes until the EOF byte, then go to IDLE.
- Descriptor: one-entry register. It clears on desc_valid_o & desc_ready_i.
- Counters saturate at 0xFFFF.

## Timing
- Buffer write outputs are registered, one cycle after the input byte. buf_we_o is never asserted for a rolled-back overflow byte.
- desc_valid_o rises the cycle after commit, which is EOF + VERDICT_WAIT + 1 at the earliest.
- desc_* outputs hold stable while desc_valid_o & !desc_ready_i.
- invalid_frame_i outside RECV/VERDICT has no effect.
- Reset values:
  - State IDLE; all pointers 0.
  - All outputs 0: buf_we_o, buf_waddr_o, buf_wdata_o, desc_valid_o, desc_start_o, desc_len_o, and both counters.
- Reset mid-frame discards the partial frame. Because rd_ptr_i is external, the consumer must be reset together with this block.

## Structure
- Put in mac_if_pkg: the state enum `rx_commit_state_t` and a descriptor struct `rx_desc_t` {start, len}.
- One sub-module is natural: `sat_counter` (16-bit saturating increment), instantiated twice for the drop counters.

## Test plan
- 64-byte good frame, no invalid pulse → 64 writes at addresses 0..63; desc start=0, len=64 at EOF+5.
- Same frame, invalid_frame_i at EOF+2 → no descriptor; drop_crc_cnt_o=1; the next frame's desc start=0.
- ADDR_W=6, rd_ptr_i=0, good 40-byte frame then a 40-byte frame → second frame dropped at byte 25; drop_ovf_cnt_o=1; wr_ptr returns to 40.
- desc_ready_i held 0 and two good frames → first desc held stable; second frame dropped as ovf; on ready=1 the first desc is accepted once.
- rd_ptr_i advanced so a frame spans address 2^ADDR_W−1 → writes wrap to 0; desc start and len correct.
- Reset asserted at byte 30 of a frame → all outputs 0 immediately; the following frame commits at start=0.
